// File: rtl/gesture_pkg.sv
// ============================================================================
// gesture_pkg: frame geometry, coordinate width and FSM states shared by
// palm location and finger identification.  Rev 1.0
// ============================================================================
`default_nettype none

package gesture_pkg;

  localparam int IMAGE_WIDTH  = 120;
  localparam int IMAGE_HEIGHT = 160;
  localparam int COORD_W      = 8;

  localparam logic [COORD_W-1:0] c_last_col  = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] c_last_row  = COORD_W'(IMAGE_HEIGHT - 1);
  localparam logic [COORD_W-1:0] c_coord_max = '1;

  typedef enum logic [0:0] {
    SCAN    = 1'b0,
    PUBLISH = 1'b1
  } palm_state_t;

endpackage

`default_nettype wire

// File: rtl/row_run_accumulator.sv
// ============================================================================
// row_run_accumulator: white count and min/max white column of the current row.
// Rev 1.0
// ============================================================================
`default_nettype none

module row_run_accumulator
  import gesture_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic               i_pixel,
  input  logic [COORD_W-1:0] i_col,
  input  logic               i_row_end,
  output logic [COORD_W-1:0] o_count,
  output logic [COORD_W-1:0] o_min,
  output logic [COORD_W-1:0] o_max
);

  logic [COORD_W-1:0] r_count;
  logic [COORD_W-1:0] r_min;
  logic [COORD_W-1:0] r_max;
  logic               w_hit;

  // Outputs already fold in the pixel on this edge so the row-end merge sees it.
  assign w_hit   = i_valid & i_pixel;
  assign o_count = (w_hit && (r_count != c_coord_max)) ? r_count + 1'b1 : r_count;
  assign o_min   = (w_hit && (i_col < r_min)) ? i_col : r_min;
  assign o_max   = (w_hit && (i_col > r_max)) ? i_col : r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_min   <= c_coord_max;
      r_max   <= '0;
    end else if (i_valid) begin
      if (i_row_end) begin
        r_count <= '0;
        r_min   <= c_coord_max;
        r_max   <= '0;
      end else begin
        r_count <= o_count;
        r_min   <= o_min;
        r_max   <= o_max;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/palm_locator.sv
// ============================================================================
// palm_locator: bounding box of rows whose white density reaches ROW_THRESH,
// published once per 120x160 frame.  Rev 1.0
// ============================================================================
`default_nettype none

module palm_locator
  import gesture_pkg::*;
#(
  parameter int ROW_THRESH = 20,
  parameter int MIN_ROWS   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               object_image,
  input  logic               pixel_valid,
  output logic [COORD_W-1:0] palm_width,
  output logic [COORD_W-1:0] palm_height,
  output logic [COORD_W-1:0] start_of_palm_r,
  output logic [COORD_W-1:0] start_of_palm_c,
  output logic [COORD_W-1:0] end_of_palm_r,
  output logic [COORD_W-1:0] end_of_palm_c,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] c_row_thresh = COORD_W'(ROW_THRESH);
  localparam logic [COORD_W-1:0] c_min_rows   = COORD_W'(MIN_ROWS);

  palm_state_t        r_state;
  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_start_r;
  logic [COORD_W-1:0] r_end_r;
  logic [COORD_W-1:0] r_start_c;
  logic [COORD_W-1:0] r_end_c;
  logic [COORD_W-1:0] r_qual_rows;
  logic               r_have_first;

  logic [COORD_W-1:0] w_row_cnt;
  logic [COORD_W-1:0] w_row_min;
  logic [COORD_W-1:0] w_row_max;
  logic               w_row_end;
  logic               w_frame_end;
  logic               w_row_qual;

  assign w_row_end   = pixel_valid && (r_col == c_last_col);
  assign w_frame_end = w_row_end && (r_row == c_last_row);
  assign w_row_qual  = w_row_end && (w_row_cnt >= c_row_thresh);

  row_run_accumulator u_row_acc (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (pixel_valid),
    .i_pixel   (object_image),
    .i_col     (r_col),
    .i_row_end (w_row_end),
    .o_count   (w_row_cnt),
    .o_min     (w_row_min),
    .o_max     (w_row_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixel_valid) begin
      if (r_col == c_last_col) begin
        r_col <= '0;
        r_row <= (r_row == c_last_row) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= SCAN;
      r_start_r       <= '0;
      r_end_r         <= '0;
      r_start_c       <= c_coord_max;
      r_end_c         <= '0;
      r_qual_rows     <= '0;
      r_have_first    <= 1'b0;
      palm_width      <= '0;
      palm_height     <= '0;
      start_of_palm_r <= '0;
      start_of_palm_c <= '0;
      end_of_palm_r   <= '0;
      end_of_palm_c   <= '0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        SCAN: begin
          // The final row merges on the same edge that moves to PUBLISH.
          if (w_row_qual) begin
            if (!r_have_first) begin
              r_start_r <= r_row;
            end
            r_have_first <= 1'b1;
            r_end_r      <= r_row;
            r_start_c    <= (w_row_min < r_start_c) ? w_row_min : r_start_c;
            r_end_c      <= (w_row_max > r_end_c) ? w_row_max : r_end_c;
            r_qual_rows  <= (r_qual_rows == c_coord_max) ? r_qual_rows
                                                         : r_qual_rows + 1'b1;
          end
          if (w_frame_end) begin
            r_state <= PUBLISH;
          end
        end
        PUBLISH: begin
          if (r_qual_rows >= c_min_rows) begin
            palm_width      <= r_end_c - r_start_c + 1'b1;
            palm_height     <= r_end_r - r_start_r + 1'b1;
            start_of_palm_r <= r_start_r;
            start_of_palm_c <= r_start_c;
            end_of_palm_r   <= r_end_r;
            end_of_palm_c   <= r_end_c;
          end else begin
            palm_width      <= '0;
            palm_height     <= '0;
            start_of_palm_r <= '0;
            start_of_palm_c <= '0;
            end_of_palm_r   <= '0;
            end_of_palm_c   <= '0;
          end
          frame_done   <= 1'b1;
          r_start_c    <= c_coord_max;
          r_end_c      <= '0;
          r_qual_rows  <= '0;
          r_have_first <= 1'b0;
          r_state      <= SCAN;
        end
        default: r_state <= SCAN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_palm_locator.sv
// ============================================================================
// tb_palm_locator: frame-level stimulus for palm_locator with a pixel-map model.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_palm_locator;

  localparam int ROWS   = 160;
  localparam int COLS   = 120;
  localparam int THRESH = 20;
  localparam int MINR   = 8;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] sr;
    logic [7:0] sc;
    logic [7:0] er;
    logic [7:0] ec;
  } box_t;

  typedef struct {
    int   r0, r1, c0, c1;
    int   r2, r3, c2, c3;
    bit   noise;
    int   gap;
    bit   b2b;
    box_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       object_image = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] palm_width, palm_height;
  logic [7:0] start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c;
  logic       frame_done;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_edge = -10;
  int   published = 0;
  box_t held = '0;
  box_t exp_q[$];
  bit   img[ROWS][COLS];
  vec_t vecs[3];

  palm_locator #(.ROW_THRESH(THRESH), .MIN_ROWS(MINR)) dut (
    .clk             (clk),
    .rst             (rst),
    .object_image    (object_image),
    .pixel_valid     (pixel_valid),
    .palm_width      (palm_width),
    .palm_height     (palm_height),
    .start_of_palm_r (start_of_palm_r),
    .start_of_palm_c (start_of_palm_c),
    .end_of_palm_r   (end_of_palm_r),
    .end_of_palm_c   (end_of_palm_c),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic box_t mk_box(int w, int h, int sr, int sc, int er, int ec);
    box_t b;
    b.w = 8'(w); b.h = 8'(h); b.sr = 8'(sr); b.sc = 8'(sc); b.er = 8'(er); b.ec = 8'(ec);
    return b;
  endfunction

  // Reference: count whites per row from the pixel map, keep rows >= THRESH.
  function automatic box_t model();
    int q = 0, sr = -1, er = 0, sc = 255, ec = 0;
    for (int r = 0; r < ROWS; r++) begin
      int cnt = 0, mn = 255, mx = 0;
      for (int c = 0; c < COLS; c++) begin
        if (img[r][c]) begin
          cnt++;
          if (c < mn) mn = c;
          if (c > mx) mx = c;
        end
      end
      if (cnt >= THRESH) begin
        q++;
        if (sr < 0) sr = r;
        er = r;
        if (mn < sc) sc = mn;
        if (mx > ec) ec = mx;
      end
    end
    if (q >= MINR) return mk_box(ec - sc + 1, er - sr + 1, sr, sc, er, ec);
    return '0;
  endfunction

  task automatic clear_img();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = 1'b0;
  endtask

  task automatic fill_rect(input int r0, input int r1, input int c0, input int c1);
    if (r0 < 0) return;
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++)
        img[r][c] = 1'b1;
  endtask

  // Idle cycles carry junk on object_image to show it is ignored while stalled.
  task automatic drive_frame(input int last_row, input int gap_mod);
    for (int r = 0; r <= last_row; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (gap_mod > 0) begin
          while ($urandom_range(gap_mod - 1) == 0) begin
            pixel_valid  = 1'b0;
            object_image = 1'($urandom_range(1));
            @(posedge clk); #1;
          end
        end
        pixel_valid  = 1'b1;
        object_image = img[r][c];
        @(posedge clk); #1;
      end
    end
    if (last_row == ROWS - 1) last_edge = cyc;
    pixel_valid  = 1'b0;
    object_image = 1'b0;
  endtask

  task automatic wait_publish();
    repeat (3) @(posedge clk);
    #1;
    check("publish_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    box_t cur;
    box_t e;
    cur = {palm_width, palm_height, start_of_palm_r, start_of_palm_c,
           end_of_palm_r, end_of_palm_c};
    if (rst) begin
      held = '0;
    end else if (frame_done) begin
      published++;
      check("frame_done_latency", cyc - last_edge, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("palm_width", int'(cur.w), int'(e.w));
        check("palm_height", int'(cur.h), int'(e.h));
        check("start_of_palm_r", int'(cur.sr), int'(e.sr));
        check("start_of_palm_c", int'(cur.sc), int'(e.sc));
        check("end_of_palm_r", int'(cur.er), int'(e.er));
        check("end_of_palm_c", int'(cur.ec), int'(e.ec));
        held = e;
      end
    end else begin
      total++;
      if (cur != held) begin
        bad++;
        $display("FAIL hold_between_publishes: got %h, want %h", cur, held);
      end
    end
  end

  initial begin
    int r0, c0;
    vecs[0] = '{10, 14, 0, 49, 100, 119, 50, 68, 1'b0, 0, 1'b0, mk_box(0, 0, 0, 0, 0, 0)};
    vecs[1] = '{40, 79, 30, 69, -1, 0, 0, 0, 1'b1, 16, 1'b1, mk_box(40, 40, 40, 30, 79, 69)};
    vecs[2] = '{120, 159, 90, 119, -1, 0, 0, 0, 1'b0, 16, 1'b0, mk_box(30, 40, 120, 90, 159, 119)};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_width", int'(palm_width), 0);
    check("reset_height", int'(palm_height), 0);
    check("reset_start_r", int'(start_of_palm_r), 0);
    check("reset_start_c", int'(start_of_palm_c), 0);
    check("reset_end_r", int'(end_of_palm_r), 0);
    check("reset_end_c", int'(end_of_palm_c), 0);
    check("reset_frame_done", int'(frame_done), 0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      clear_img();
      fill_rect(vecs[i].r0, vecs[i].r1, vecs[i].c0, vecs[i].c1);
      fill_rect(vecs[i].r2, vecs[i].r3, vecs[i].c2, vecs[i].c3);
      if (vecs[i].noise) begin
        for (int r = 0; r <= 10; r++) img[r][(r * 11) % COLS] = 1'b1;
        img[150][60] = 1'b1;
      end
      exp_q.push_back(vecs[i].exp);
      drive_frame(ROWS - 1, vecs[i].gap);
      if (!vecs[i].b2b) wait_publish();
    end

    // Partial frame that would qualify, then reset at the start of row 80.
    clear_img();
    fill_rect(40, 79, 0, 119);
    drive_frame(79, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_width", int'(palm_width), 0);
    check("midreset_height", int'(palm_height), 0);
    check("midreset_start_r", int'(start_of_palm_r), 0);
    check("midreset_start_c", int'(start_of_palm_c), 0);
    check("midreset_end_r", int'(end_of_palm_r), 0);
    check("midreset_end_c", int'(end_of_palm_c), 0);
    check("midreset_frame_done", int'(frame_done), 0);
    rst = 1'b0;

    // Random frame: exactly MINR rows of exactly THRESH whites, sparse noise elsewhere.
    clear_img();
    r0 = int'($urandom_range(ROWS - MINR));
    c0 = int'($urandom_range(COLS - THRESH));
    fill_rect(r0, r0 + MINR - 1, c0, c0 + THRESH - 1);
    for (int r = 0; r < ROWS; r++) begin
      if ((r < r0 || r >= r0 + MINR) && $urandom_range(3) == 0) begin
        for (int k = 0; k < 3; k++) img[r][$urandom_range(COLS - 1)] = 1'b1;
      end
    end
    exp_q.push_back(model());
    drive_frame(ROWS - 1, 16);
    wait_publish();

    check("publish_count", published, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
